pipe_hazard_ctl: RTL and testbench
==================================

// Module: pipe_hazard_ctl
// PURPOSE
//  Central stall/flush sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers.
//  Detects load-use hazards, rename free-list exhaustion and data-memory wait.
//  Runs branch-mispredict recovery: flush, PC redirect, then a multi-cycle checkpoint restore.
//  Drives each pipe stage's i_Stall/i_Flush.
//  Pipe-register contract: stall holds the register; a flush is honoured only when not stalled.
// PARAMETERS
//  REG_ADDR_WIDTH    5   architectural reg addr width; physical addr is REG_ADDR_WIDTH+1 bits
//  CHECKPOINT_WIDTH  2   rename checkpoint tag width
//  RESTORE_CYCLES    2   cycles spent in RECOVER (legal range 1..15)
//  PERF_WIDTH        16  width of the stall-cycle performance counter
// PORTS
//  i_Clk                   in   1     clock, rising edge
//  i_Reset                 in   1     synchronous reset, active high
//  i_Dec_Uses_Src1         in   1     decode instr reads src1
//  i_Dec_PSrc1_Addr        in   RAW+1 decode physical src1 (RAW=REG_ADDR_WIDTH)
//  i_Dec_Uses_Src2         in   1     decode instr reads src2
//  i_Dec_PSrc2_Addr        in   RAW+1 decode physical src2
//  i_Ex_Mem_Valid          in   1     EX instr accesses memory
//  i_Ex_Mem_Read_Write_n   in   1     1=load
//  i_Ex_Writes_Back        in   1     EX instr writes a register
//  i_Ex_PWrite_Addr        in   RAW+1 EX physical destination
//  i_Free_List_Empty       in   1     rename cannot allocate
//  i_Mem_Busy              in   1     data memory not ready this cycle
//  i_Branch_Resolved       in   1     branch in EX resolved this cycle
//  i_Branch_Mispredict     in   1     qualifies i_Branch_Resolved
//  i_Branch_Checkpoint     in   CW    checkpoint of the mispredicted branch
//  o_Stall_IF_ID/o_Stall_ID_EX/o_Stall_EX_MEM  out  1 each  hold the named pipe register
//  o_Flush_IF_ID/o_Flush_ID_EX/o_Flush_MEM_WB  out  1 each  insert a bubble into it
//  o_PC_Redirect           out  1     fetch loads the corrected target this cycle
//  o_Restore_Valid         out  1     one-cycle pulse: rename restores o_Restore_Checkpoint
//  o_Restore_Checkpoint    out  CW    registered checkpoint tag
//  o_State                 out  2     0=RUN, 1=MEM_WAIT, 2=RECOVER
//  o_Stall_Count           out  PERF  saturating count of cycles with o_Stall_IF_ID=1
// BEHAVIOUR
//  Reset (sync): state=RUN, counter=0, pending=0, o_Restore_Valid=0,
//   o_Restore_Checkpoint=0, o_Stall_Count=0.
//   During the reset cycle all stall/flush/redirect outputs are 0.
//  Stall/flush/redirect outputs are combinational from state and inputs, with zero latency.
//  LU (load-use) = Ex_Mem_Valid & Read_Write_n & Writes_Back & PWrite_Addr!=0 &
//   ((Uses_Src1 & PSrc1==PWrite) | (Uses_Src2 & PSrc2==PWrite)).
//  MP = i_Branch_Resolved & i_Branch_Mispredict.
//  RUN, priority order:
//   1. Mem_Busy: Stall IF_ID, ID_EX, EX_MEM; Flush_MEM_WB. Next state MEM_WAIT.
//      If MP is also asserted: pending=1, checkpoint captured, no redirect.
//   2. MP: Flush IF_ID and ID_EX; PC_Redirect=1; capture checkpoint.
//      Next state RECOVER, counter=RESTORE_CYCLES-1.
//   3. LU or Free_List_Empty: Stall IF_ID; Flush_ID_EX.
//   4. Otherwise all outputs 0.
//  MEM_WAIT: same outputs as RUN case 1 while Mem_Busy=1. MP is still captured into pending.
//   When Mem_Busy=0:
//    - pending=1: act as RUN case 2 this cycle (flush, redirect), clear pending, go to RECOVER.
//    - pending=0: evaluate RUN cases 2-4, return to RUN.
//  RECOVER: Stall IF_ID; Flush_ID_EX; EX_MEM and MEM_WB flow so older instrs drain.
//   o_Restore_Valid=1 in the first RECOVER cycle only.
//   Counter decrements each cycle; at 0 the next state is RUN.
//   MP and LU are ignored in RECOVER.
//   Mem_Busy in RECOVER: also Stall EX_MEM and Flush MEM_WB; the counter still runs.
//  o_Stall_Count increments on any cycle with o_Stall_IF_ID=1 and saturates at all-ones.
//  Reset asserted mid-RECOVER or mid-MEM_WAIT aborts immediately:
//   pending is dropped and no restore pulse is issued.
// TESTING
//  LU: EX load with PWrite=9; decode with Uses_Src2=1, PSrc2=9
//   -> 1 cycle with Stall_IF_ID=1, Flush_ID_EX=1. Same case with PWrite=0 -> no stall.
//  MP in RUN, RESTORE_CYCLES=2, checkpoint=3
//   -> same cycle: Flush IF_ID/ID_EX=1, Redirect=1.
//   -> next 2 cycles: o_State=2; Restore_Valid=1 only in the first, Restore_Checkpoint=3.
//   -> then o_State=0.
//  Mem_Busy high for 3 cycles, MP in cycle 2, checkpoint=1
//   -> 3 cycles of Stall IF_ID/ID_EX/EX_MEM and Flush_MEM_WB.
//   -> Redirect in cycle 4; Restore_Valid=1 with checkpoint 1 in cycle 5.
//  Reset asserted in the first RECOVER cycle
//   -> next cycle o_State=0, Restore_Valid=0, all stalls 0.
//  Free_List_Empty held for 70000 cycles with PERF_WIDTH=16
//   -> o_Stall_Count=16'hFFFF (saturated, no wrap).

Source files
------------

// File: rtl/pipe_hazard_ctl.sv
// Stall/flush sequencer for the four pipe registers: load-use, free-list and
// data-memory hazards plus branch-mispredict flush, redirect and checkpoint restore.
module pipe_hazard_ctl #(
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int CHECKPOINT_WIDTH = 2,
  parameter int RESTORE_CYCLES   = 2,
  parameter int PERF_WIDTH       = 16
) (
  input  logic                        i_Clk,
  input  logic                        i_Reset,
  input  logic                        i_Dec_Uses_Src1,
  input  logic [REG_ADDR_WIDTH:0]     i_Dec_PSrc1_Addr,
  input  logic                        i_Dec_Uses_Src2,
  input  logic [REG_ADDR_WIDTH:0]     i_Dec_PSrc2_Addr,
  input  logic                        i_Ex_Mem_Valid,
  input  logic                        i_Ex_Mem_Read_Write_n,
  input  logic                        i_Ex_Writes_Back,
  input  logic [REG_ADDR_WIDTH:0]     i_Ex_PWrite_Addr,
  input  logic                        i_Free_List_Empty,
  input  logic                        i_Mem_Busy,
  input  logic                        i_Branch_Resolved,
  input  logic                        i_Branch_Mispredict,
  input  logic [CHECKPOINT_WIDTH-1:0] i_Branch_Checkpoint,
  output logic                        o_Stall_IF_ID,
  output logic                        o_Stall_ID_EX,
  output logic                        o_Stall_EX_MEM,
  output logic                        o_Flush_IF_ID,
  output logic                        o_Flush_ID_EX,
  output logic                        o_Flush_MEM_WB,
  output logic                        o_PC_Redirect,
  output logic                        o_Restore_Valid,
  output logic [CHECKPOINT_WIDTH-1:0] o_Restore_Checkpoint,
  output logic [1:0]                  o_State,
  output logic [PERF_WIDTH-1:0]       o_Stall_Count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_RECOVER  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(RESTORE_CYCLES - 1);

  state_t                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic                        pending_q, pending_d;
  logic [CHECKPOINT_WIDTH-1:0] pend_cp_q, pend_cp_d;
  logic                        restore_valid_q, restore_valid_d;
  logic [CHECKPOINT_WIDTH-1:0] restore_cp_q, restore_cp_d;
  logic [PERF_WIDTH-1:0]       stall_count_q, stall_count_d;

  logic                        lu, mp, in_recover, take_mp, hazard;
  logic [CHECKPOINT_WIDTH-1:0] redirect_cp;

  assign lu = i_Ex_Mem_Valid & i_Ex_Mem_Read_Write_n & i_Ex_Writes_Back &
              (i_Ex_PWrite_Addr != '0) &
              ((i_Dec_Uses_Src1 & (i_Dec_PSrc1_Addr == i_Ex_PWrite_Addr)) |
               (i_Dec_Uses_Src2 & (i_Dec_PSrc2_Addr == i_Ex_PWrite_Addr)));
  assign mp = i_Branch_Resolved & i_Branch_Mispredict;

  // pending is only ever set on the way into MEM_WAIT, so outside RECOVER a
  // non-busy cycle with pending (or a fresh mispredict) starts recovery.
  assign in_recover  = (state_q == ST_RECOVER);
  assign take_mp     = ~in_recover & ~i_Mem_Busy & (pending_q | mp);
  assign hazard      = ~in_recover & ~i_Mem_Busy & ~take_mp & (lu | i_Free_List_Empty);
  assign redirect_cp = pending_q ? pend_cp_q : i_Branch_Checkpoint;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q         <= ST_RUN;
      cnt_q           <= '0;
      pending_q       <= 1'b0;
      pend_cp_q       <= '0;
      restore_valid_q <= 1'b0;
      restore_cp_q    <= '0;
      stall_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pending_q       <= pending_d;
      pend_cp_q       <= pend_cp_d;
      restore_valid_q <= restore_valid_d;
      restore_cp_q    <= restore_cp_d;
      stall_count_q   <= stall_count_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pending_d       = pending_q;
    pend_cp_d       = pend_cp_q;
    restore_valid_d = 1'b0;
    restore_cp_d    = restore_cp_q;
    stall_count_d   = stall_count_q;
    if (o_Stall_IF_ID && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
    case (state_q)
      ST_RECOVER: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        if (i_Mem_Busy) begin
          state_d = ST_MEM_WAIT;
          if (mp) begin
            pending_d = 1'b1;
            pend_cp_d = i_Branch_Checkpoint;
          end
        end else if (take_mp) begin
          state_d         = ST_RECOVER;
          cnt_d           = CNT_INIT;
          pending_d       = 1'b0;
          restore_valid_d = 1'b1;
          restore_cp_d    = redirect_cp;
        end else begin
          state_d = ST_RUN;
        end
      end
    endcase
  end

  always_comb begin
    o_Stall_IF_ID  = 1'b0;
    o_Stall_ID_EX  = 1'b0;
    o_Stall_EX_MEM = 1'b0;
    o_Flush_IF_ID  = 1'b0;
    o_Flush_ID_EX  = 1'b0;
    o_Flush_MEM_WB = 1'b0;
    o_PC_Redirect  = 1'b0;
    if (!i_Reset) begin
      o_Stall_IF_ID  = (i_Mem_Busy & ~in_recover) | hazard | in_recover;
      o_Stall_ID_EX  = i_Mem_Busy & ~in_recover;
      o_Stall_EX_MEM = i_Mem_Busy;
      o_Flush_MEM_WB = i_Mem_Busy;
      o_Flush_IF_ID  = take_mp;
      o_Flush_ID_EX  = take_mp | hazard | in_recover;
      o_PC_Redirect  = take_mp;
    end
  end

  assign o_Restore_Valid      = restore_valid_q;
  assign o_Restore_Checkpoint = restore_cp_q;
  assign o_State              = state_q;
  assign o_Stall_Count        = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Bench for pipe_hazard_ctl: per-cycle behavioural model check plus directed
// scenarios with literal expectations.
module tb_pipe_hazard_ctl;
  localparam int RAW = 5;
  localparam int CW  = 2;
  localparam int RC  = 2;
  localparam int PW  = 16;

  logic           clk, rst;
  logic           uses1, uses2, mem_valid, mem_rd, wb, fle, busy, br_res, br_mis;
  logic [RAW:0]   psrc1, psrc2, pwr;
  logic [CW-1:0]  ckpt;
  logic           s_ifid, s_idex, s_exmem, f_ifid, f_idex, f_memwb, redir, rv;
  logic [CW-1:0]  rcp;
  logic [1:0]     st;
  logic [PW-1:0]  scnt;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  pipe_hazard_ctl #(.REG_ADDR_WIDTH(RAW), .CHECKPOINT_WIDTH(CW),
                    .RESTORE_CYCLES(RC), .PERF_WIDTH(PW)) dut (
    .i_Clk(clk), .i_Reset(rst),
    .i_Dec_Uses_Src1(uses1), .i_Dec_PSrc1_Addr(psrc1),
    .i_Dec_Uses_Src2(uses2), .i_Dec_PSrc2_Addr(psrc2),
    .i_Ex_Mem_Valid(mem_valid), .i_Ex_Mem_Read_Write_n(mem_rd),
    .i_Ex_Writes_Back(wb), .i_Ex_PWrite_Addr(pwr),
    .i_Free_List_Empty(fle), .i_Mem_Busy(busy),
    .i_Branch_Resolved(br_res), .i_Branch_Mispredict(br_mis),
    .i_Branch_Checkpoint(ckpt),
    .o_Stall_IF_ID(s_ifid), .o_Stall_ID_EX(s_idex), .o_Stall_EX_MEM(s_exmem),
    .o_Flush_IF_ID(f_ifid), .o_Flush_ID_EX(f_idex), .o_Flush_MEM_WB(f_memwb),
    .o_PC_Redirect(redir), .o_Restore_Valid(rv), .o_Restore_Checkpoint(rcp),
    .o_State(st), .o_Stall_Count(scnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: mode 0=RUN 1=MEM_WAIT 2=RECOVER; m_rem counts RECOVER cycles still to run.
  int m_mode = 0, m_rem = 0, m_pcp = 0, m_rcp = 0, m_cnt = 0;
  bit m_pend = 0, m_first = 0;

  always @(negedge clk) begin
    int n_mode, n_rem, n_pcp, n_rcp, n_cnt;
    bit n_pend, n_first, mp, lu;
    bit e_sif, e_sie, e_sem, e_fif, e_fie, e_fmw, e_red;
    n_mode = m_mode; n_rem = m_rem; n_pcp = m_pcp; n_rcp = m_rcp; n_cnt = m_cnt;
    n_pend = m_pend; n_first = 0;
    {e_sif, e_sie, e_sem, e_fif, e_fie, e_fmw, e_red} = '0;
    mp = br_res && br_mis;
    lu = mem_valid && mem_rd && wb && (pwr != 0) &&
         ((uses1 && psrc1 == pwr) || (uses2 && psrc2 == pwr));
    if (rst) begin
      n_mode = 0; n_rem = 0; n_pend = 0; n_pcp = 0; n_rcp = 0; n_cnt = 0;
    end else begin
      if (m_mode == 2) begin
        e_sif = 1; e_fie = 1;
        if (busy) begin e_sem = 1; e_fmw = 1; end
        n_rem = m_rem - 1;
        if (n_rem == 0) n_mode = 0;
      end else if (busy) begin
        e_sif = 1; e_sie = 1; e_sem = 1; e_fmw = 1;
        n_mode = 1;
        if (mp) begin n_pend = 1; n_pcp = int'(ckpt); end
      end else if (m_pend || mp) begin
        e_fif = 1; e_fie = 1; e_red = 1;
        n_mode = 2; n_rem = RC; n_first = 1; n_pend = 0;
        n_rcp = m_pend ? m_pcp : int'(ckpt);
      end else begin
        n_mode = 0;
        if (lu || fle) begin e_sif = 1; e_fie = 1; end
      end
      if (e_sif && m_cnt < 65535) n_cnt = m_cnt + 1;
    end
    if (chk_en) begin
      chk("stall_if_id", int'(s_ifid), int'(e_sif));
      chk("stall_id_ex", int'(s_idex), int'(e_sie));
      chk("stall_ex_mem", int'(s_exmem), int'(e_sem));
      chk("flush_if_id", int'(f_ifid), int'(e_fif));
      chk("flush_id_ex", int'(f_idex), int'(e_fie));
      chk("flush_mem_wb", int'(f_memwb), int'(e_fmw));
      chk("pc_redirect", int'(redir), int'(e_red));
      chk("state", int'(st), m_mode);
      chk("restore_valid", int'(rv), int'(m_first));
      chk("restore_ckpt", int'(rcp), m_rcp);
      chk("stall_count", int'(scnt), m_cnt);
    end
    m_mode = n_mode; m_rem = n_rem; m_pcp = n_pcp; m_rcp = n_rcp;
    m_cnt = n_cnt; m_pend = n_pend; m_first = n_first;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    {uses1, uses2, mem_valid, mem_rd, wb, fle, busy, br_res, br_mis} = '0;
    psrc1 = '0; psrc2 = '0; pwr = '0; ckpt = '0;
  endtask

  task automatic mispredict(input logic [CW-1:0] c);
    br_res = 1'b1; br_mis = 1'b1; ckpt = c;
  endtask

  // {busy, fle, mp, load-use} mixes checked only by the model
  logic [3:0] mix [8] = '{4'b0001, 4'b0100, 4'b0011, 4'b1001, 4'b0110, 4'b1100, 4'b0000, 4'b1110};

  initial begin
    clr();
    rst = 1'b1;
    tick(); chk_en = 1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", int'(st), 0);
    chk("reset_count", int'(scnt), 0);
    tick();

    // Load-use on src2 with PWrite=9
    mem_valid = 1; mem_rd = 1; wb = 1; pwr = 6'd9; uses2 = 1; psrc2 = 6'd9;
    @(negedge clk);
    chk("lu_stall", int'(s_ifid), 1);
    chk("lu_flush", int'(f_idex), 1);
    chk("lu_no_exmem", int'(s_exmem), 0);
    tick();
    pwr = 6'd0; psrc2 = 6'd0;
    @(negedge clk);
    chk("lu_zero_reg", int'(s_ifid), 0);
    tick();
    clr();

    // Mispredict from RUN
    mispredict(2'd3);
    @(negedge clk);
    chk("mp_flush_ifid", int'(f_ifid), 1);
    chk("mp_flush_idex", int'(f_idex), 1);
    chk("mp_redirect", int'(redir), 1);
    tick(); clr();
    @(negedge clk);
    chk("rec1_state", int'(st), 2);
    chk("rec1_rv", int'(rv), 1);
    chk("rec1_ckpt", int'(rcp), 3);
    tick();
    @(negedge clk);
    chk("rec2_state", int'(st), 2);
    chk("rec2_rv", int'(rv), 0);
    tick();
    @(negedge clk);
    chk("rec_done", int'(st), 0);
    tick();

    // Mem_Busy for 3 cycles with a mispredict in cycle 2
    busy = 1;
    @(negedge clk);
    chk("mw1_stall", int'({s_ifid, s_idex, s_exmem, f_memwb}), 15);
    tick();
    mispredict(2'd1);
    @(negedge clk);
    chk("mw2_noredir", int'(redir), 0);
    chk("mw2_state", int'(st), 1);
    tick();
    br_res = 0; br_mis = 0; ckpt = 2'd2;
    @(negedge clk);
    chk("mw3_stall", int'({s_ifid, s_idex, s_exmem, f_memwb}), 15);
    tick();
    busy = 0;
    @(negedge clk);
    chk("mw4_redirect", int'(redir), 1);
    tick();
    @(negedge clk);
    chk("mw5_rv", int'(rv), 1);
    chk("mw5_ckpt", int'(rcp), 1);
    // Mem_Busy during RECOVER drains nothing below EX
    busy = 1;
    @(negedge clk);
    chk("rec_busy_exmem", int'(s_exmem), 1);
    tick(); busy = 0;
    tick(); tick();

    // Reset in first RECOVER cycle
    mispredict(2'd2);
    tick(); clr();
    rst = 1;
    @(negedge clk);
    chk("rst_rec_outs", int'({s_ifid, f_idex, redir}), 0);
    tick(); rst = 0;
    @(negedge clk);
    chk("rst_rec_state", int'(st), 0);
    chk("rst_rec_rv", int'(rv), 0);
    chk("rst_rec_stall", int'(s_ifid), 0);
    tick();

    // Reset mid-MEM_WAIT drops the pending mispredict
    busy = 1; mispredict(2'd3);
    tick(); clr(); busy = 1; rst = 1;
    tick(); clr(); rst = 0;
    @(negedge clk);
    chk("rst_mw_redirect", int'(redir), 0);
    tick();
    @(negedge clk);
    chk("rst_mw_rv", int'(rv), 0);
    chk("rst_mw_state", int'(st), 0);
    tick();

    // Mixed input vectors, model-checked
    for (int i = 0; i < 8; i++) begin
      clr();
      busy = mix[i][3]; fle = mix[i][2];
      if (mix[i][1]) mispredict(2'(i));
      if (mix[i][0]) begin
        mem_valid = 1; mem_rd = 1; wb = 1; pwr = 6'd17; uses1 = 1; psrc1 = 6'd17;
      end
      tick();
    end
    clr();
    repeat (4) tick();

    // Stall counter saturation
    fle = 1;
    repeat (70000) tick();
    @(negedge clk);
    chk("sat_count", int'(scnt), 65535);
    tick();
    @(negedge clk);
    chk("sat_hold", int'(scnt), 65535);
    clr();
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
